// File: rtl/spi_word_link_pkg.sv
// Shared defaults and FSM state type for the SPI word link.
// Pure declarations; no logic, no latency.
// Not applicable: carries no handshake.
package spi_link_pkg;

    localparam int               WORD_W_DEF    = 16;
    localparam int               HOLD_CYC_DEF  = 4;
    localparam logic [15:0]      IDLE_WORD_DEF = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } link_state_t;

endpackage

// File: rtl/spi_word_link_if.sv
// Groups the pad-side SPI pins and the core-side word/strobe signals.
// Wires only; no latency.
// No backpressure: the core edge-detects held levels, SPI is master-paced.
interface spi_word_link_if
    import spi_link_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_done;
    logic              frame_err;
    logic              tx_overrun;

    // The link block itself: pads and core strobes come in, words go out.
    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, rx_data, rx_valid, tx_done, frame_err, tx_overrun
    );

    // The SPI master plus core side that talks to the link.
    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, rx_data, rx_valid, tx_done, frame_err, tx_overrun
    );
endinterface

// File: rtl/spi_word_link_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with rise/fall pulses.
// Pulses appear 2-3 clk after the input edge, one cycle wide.
// No backpressure; every qualified edge produces exactly one pulse.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability pair followed by a history flop for edge detection.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise =  r_sync & ~r_prev;
    assign o_fall = ~r_sync &  r_prev;
endmodule

// File: rtl/spi_word_link.sv
// SPI mode-0 slave: 16-bit MOSI frames to a held word/valid, core words out on MISO.
// rx word lands ~3 clk after the 16th SCLK rise; MISO bit updates ~3 clk after SCLK fall.
// No backpressure: valid/done are HOLD_CYC-cycle levels; a second tx word overwrites and flags overrun.
module spi_word_link
    import spi_link_pkg::*;
#(
    parameter int                WORD_W    = WORD_W_DEF,
    parameter int                HOLD_CYC  = HOLD_CYC_DEF,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(IDLE_WORD_DEF)
) (
    input  logic                  clk,
    input  logic                  rstb,
    spi_word_link_if.slave        bus
);
    localparam int HC_W = $clog2(HOLD_CYC + 1);
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [HC_W-1:0] HOLD_LD  = HC_W'(HOLD_CYC);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    link_state_t       r_state;
    logic [BC_W-1:0]   r_bitcnt;
    logic [WORD_W-2:0] r_rx_sr;
    logic [WORD_W-1:0] r_tx_sr;
    logic [WORD_W-1:0] r_rx_data;
    logic [WORD_W-1:0] r_tx_buf;
    logic              r_pending;
    logic              r_in_flight;
    logic              r_frame_err;
    logic              r_tx_overrun;
    logic              r_tx_vld_prev;
    logic [HC_W-1:0]   r_rx_hold;
    logic [HC_W-1:0]   r_tx_hold;
    logic              r_mosi_meta;
    logic              r_mosi_sync;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_word_done;
    logic w_load_take;
    logic w_restore;
    logic w_tx_edge;

    sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rstb   (rstb),
        .i_async(bus.spi_sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // cs_n idles high, so its synchroniser resets high to avoid a fake edge.
    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rstb   (rstb),
        .i_async(bus.spi_cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // MOSI takes the same two-flop delay as SCLK so it lines up with the rise pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= bus.spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_word_done = (r_state == SHIFT) && !w_cs_rise && w_sclk_rise
                         && (r_bitcnt == LAST_BIT);
    assign w_load_take = (r_state == LOAD) && !w_cs_rise;
    // A frame closed before its first bit never sent the loaded word; put it back.
    assign w_restore   = (r_state == SHIFT) && w_cs_rise && (r_bitcnt == '0)
                         && r_in_flight;
    assign w_tx_edge   = bus.tx_valid && !r_tx_vld_prev;

    // Frame FSM with rx/tx shift registers and bit counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_rx_data   <= '0;
            r_in_flight <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                    end else begin
                        r_tx_sr     <= r_pending ? r_tx_buf : IDLE_WORD;
                        r_in_flight <= r_pending;
                        r_bitcnt    <= '0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_in_flight <= 1'b0;
                        r_frame_err <= (r_bitcnt != '0);
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_sr <= {r_rx_sr[WORD_W-3:0], r_mosi_sync};
                            if (r_bitcnt == LAST_BIT) begin
                                r_rx_data   <= {r_rx_sr, r_mosi_sync};
                                r_in_flight <= 1'b0;
                                r_bitcnt    <= '0;
                                r_state     <= LOAD;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                        // The fall that trails a word's last rise must not eat the
                        // freshly loaded MSB, so only shift once a bit was taken.
                        if (w_sclk_fall && (r_bitcnt != '0)) begin
                            r_tx_sr <= {r_tx_sr[WORD_W-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Core result capture on tx_valid rising edge; LOAD consumes the pre-edge word.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_tx_vld_prev <= 1'b0;
            r_tx_buf      <= '0;
            r_pending     <= 1'b0;
            r_tx_overrun  <= 1'b0;
        end else begin
            r_tx_vld_prev <= bus.tx_valid;
            r_tx_overrun  <= 1'b0;
            if (w_tx_edge) begin
                r_tx_buf     <= bus.tx_data;
                r_pending    <= 1'b1;
                r_tx_overrun <= r_pending && !w_load_take;
            end else if (w_load_take) begin
                r_pending <= 1'b0;
            end else if (w_restore) begin
                r_pending <= 1'b1;
            end
        end
    end

    // rx_valid hold: restarts on every completed word.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rx_hold <= '0;
        end else if (w_word_done) begin
            r_rx_hold <= HOLD_LD;
        end else if (r_rx_hold != '0) begin
            r_rx_hold <= r_rx_hold - 1'b1;
        end
    end

    // tx_done hold: only for words that actually came from the core.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_tx_hold <= '0;
        end else if (w_word_done && r_in_flight) begin
            r_tx_hold <= HOLD_LD;
        end else if (r_tx_hold != '0) begin
            r_tx_hold <= r_tx_hold - 1'b1;
        end
    end

    assign bus.spi_miso   = (r_state != IDLE) ? r_tx_sr[WORD_W-1] : 1'b0;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = (r_rx_hold != '0);
    assign bus.tx_done    = (r_tx_hold != '0);
    assign bus.frame_err  = r_frame_err;
    assign bus.tx_overrun = r_tx_overrun;
endmodule
